// File: rtl/stream_buffer_if.sv
// Valid/ready stream bundle: free-running upstream capture side plus stalled consumer side.
interface stream_buffer_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dvalid;
   logic                  ready;

   modport master (
      output din, din_valid, ready,
      input  dout, dvalid
   );

   modport slave (
      input  din, din_valid, ready,
      output dout, dvalid
   );
endinterface

// File: rtl/stream_buffer.sv
// Elastic FIFO between a no-backpressure producer and a stalling consumer;
// drops words arriving while full and records the loss in a sticky flag.
module stream_buffer #(
   parameter  int unsigned DATA_WIDTH  = 32,
   parameter  int unsigned DEPTH       = 16,
   parameter  int unsigned AFULL_LEVEL = DEPTH - 2,
   localparam int unsigned AW          = $clog2(DEPTH),
   localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          ovf_clr,
   stream_buffer_if.slave s,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          afull,
   output logic          overflow
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic push, pop, wr, drop, empty;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign afull = (count_q >= CW'(AFULL_LEVEL));
   assign count = count_q;
   assign overflow = ovf_q;

   assign push = en & s.din_valid;
   assign pop  = ~empty & s.ready;
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign wr   = push & (~full | pop);
   assign drop = push & full & ~pop;

   assign s.dvalid = ~empty;
   assign s.dout   = empty ? '0 : mem[rp_q];

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (wr)  wp_d = wp_q + AW'(1);
      if (pop) rp_d = rp_q + AW'(1);
      case ({wr, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp_q] <= s.din;
   end

endmodule
